// File: rtl/mac_addressgen_pkg.sv
// Shared types for the MAC accelerator address generators: descriptor,
// status flags and the generator FSM encoding.
package mac_addressgen_pkg;

  localparam int unsigned AG_AW         = 32;
  localparam int unsigned AG_CW         = 16;
  localparam int unsigned AG_DATA_BYTES = 4;

  typedef struct packed {
    logic [AG_AW-1:0] base_addr;
    logic [AG_CW-1:0] trans_size;
    logic [AG_CW-1:0] line_length;
    logic [AG_AW-1:0] line_stride;
    logic [AG_CW-1:0] feat_length;
    logic [AG_AW-1:0] feat_stride;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_addressgen_t;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } addressgen_state_t;

  // A zero line/feature length behaves like a length of one.
  function automatic logic [AG_CW-1:0] eff_len(input logic [AG_CW-1:0] len);
    return (len == '0) ? AG_CW'(1) : len;
  endfunction

endpackage

// File: rtl/mac_addressgen.sv
// Streamer address generator: accepts a descriptor on req_start_i and emits
// a 3-level nested (word/line/feature) byte address stream with valid/ready.
module mac_addressgen
  import mac_addressgen_pkg::*;
#(
  parameter int unsigned AW         = AG_AW,
  parameter int unsigned CW         = AG_CW,
  parameter int unsigned DATA_BYTES = AG_DATA_BYTES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             req_start_i,
  input  ctrl_addressgen_t ctrl_i,
  output logic             ready_start_o,
  output logic [AW-1:0]    addr_o,
  output logic             addr_valid_o,
  output logic             addr_last_o,
  input  logic             addr_ready_i,
  output logic             done_o
);

  // Handshake: an address transfers on every rising edge where addr_valid_o
  // and addr_ready_i are both high; once raised, addr_valid_o, addr_o and
  // addr_last_o hold until that transfer happens.

  addressgen_state_t state_q, state_d;

  logic [CW-1:0] trans_size_q, trans_size_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [CW-1:0] feat_len_q, feat_len_d;
  logic [AW-1:0] line_stride_q, line_stride_d;
  logic [AW-1:0] feat_stride_q, feat_stride_d;

  logic [CW-1:0] word_idx_q, word_idx_d;
  logic [CW-1:0] line_idx_q, line_idx_d;
  logic [CW-1:0] feat_idx_q, feat_idx_d;
  logic [CW-1:0] emitted_q, emitted_d;

  logic [AW-1:0] feat_base_q, feat_base_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [AW-1:0] addr_q, addr_d;

  logic              handshake;
  logic              last_word;
  flags_addressgen_t flags;

  assign handshake = (state_q == AG_RUN) && addr_ready_i;
  assign last_word = (emitted_q == trans_size_q - CW'(1));

  always_comb begin
    state_d       = state_q;
    trans_size_d  = trans_size_q;
    line_len_d    = line_len_q;
    feat_len_d    = feat_len_q;
    line_stride_d = line_stride_q;
    feat_stride_d = feat_stride_q;
    word_idx_d    = word_idx_q;
    line_idx_d    = line_idx_q;
    feat_idx_d    = feat_idx_q;
    emitted_d     = emitted_q;
    feat_base_d   = feat_base_q;
    line_base_d   = line_base_q;
    addr_d        = addr_q;

    unique case (state_q)
      AG_IDLE: begin
        if (req_start_i) begin
          trans_size_d  = ctrl_i.trans_size;
          line_len_d    = eff_len(ctrl_i.line_length);
          feat_len_d    = eff_len(ctrl_i.feat_length);
          line_stride_d = ctrl_i.line_stride;
          feat_stride_d = ctrl_i.feat_stride;
          word_idx_d    = '0;
          line_idx_d    = '0;
          feat_idx_d    = '0;
          emitted_d     = '0;
          feat_base_d   = ctrl_i.base_addr;
          line_base_d   = ctrl_i.base_addr;
          addr_d        = ctrl_i.base_addr;
          state_d       = (ctrl_i.trans_size == '0) ? AG_DONE : AG_RUN;
        end
      end

      AG_RUN: begin
        if (handshake) begin
          emitted_d = emitted_q + CW'(1);
          if (last_word) state_d = AG_DONE;
          // Innermost counter first; each wrap carries into the next level
          // and restarts the word address from the new line/feature base.
          if (word_idx_q == line_len_q - CW'(1)) begin
            word_idx_d = '0;
            if (line_idx_q == feat_len_q - CW'(1)) begin
              line_idx_d  = '0;
              feat_idx_d  = feat_idx_q + CW'(1);
              feat_base_d = feat_base_q + feat_stride_q;
              line_base_d = feat_base_q + feat_stride_q;
              addr_d      = feat_base_q + feat_stride_q;
            end else begin
              line_idx_d  = line_idx_q + CW'(1);
              line_base_d = line_base_q + line_stride_q;
              addr_d      = line_base_q + line_stride_q;
            end
          end else begin
            word_idx_d = word_idx_q + CW'(1);
            addr_d     = addr_q + AW'(DATA_BYTES);
          end
        end
      end

      AG_DONE: state_d = AG_IDLE;

      default: state_d = AG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q       <= AG_IDLE;
      trans_size_q  <= '0;
      line_len_q    <= '0;
      feat_len_q    <= '0;
      line_stride_q <= '0;
      feat_stride_q <= '0;
      word_idx_q    <= '0;
      line_idx_q    <= '0;
      feat_idx_q    <= '0;
      emitted_q     <= '0;
      feat_base_q   <= '0;
      line_base_q   <= '0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      trans_size_q  <= trans_size_d;
      line_len_q    <= line_len_d;
      feat_len_q    <= feat_len_d;
      line_stride_q <= line_stride_d;
      feat_stride_q <= feat_stride_d;
      word_idx_q    <= word_idx_d;
      line_idx_q    <= line_idx_d;
      feat_idx_q    <= feat_idx_d;
      emitted_q     <= emitted_d;
      feat_base_q   <= feat_base_d;
      line_base_q   <= line_base_d;
      addr_q        <= addr_d;
    end
  end

  // Outputs decode registered state only; addr_o reads zero when not valid.
  assign flags.ready_start = (state_q == AG_IDLE);
  assign flags.done        = (state_q == AG_DONE);

  assign ready_start_o = flags.ready_start;
  assign done_o        = flags.done;
  assign addr_valid_o  = (state_q == AG_RUN);
  assign addr_last_o   = addr_valid_o && last_word;
  assign addr_o        = addr_valid_o ? addr_q : '0;

endmodule

// File: tb/tb_mac_addressgen.sv
// Directed bench for mac_addressgen: an address-list model built from the
// descriptor with plain arithmetic, checked every cycle by a compare process.
module tb_mac_addressgen;
  import mac_addressgen_pkg::*;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic             req_start_i;
  ctrl_addressgen_t ctrl_i;
  logic             ready_start_o;
  logic [31:0]      addr_o;
  logic             addr_valid_o;
  logic             addr_last_o;
  logic             addr_ready_i;
  logic             done_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  bit          stall_prev = 1'b0;
  bit          clr_prev   = 1'b0;

  always #5 clk = ~clk;

  mac_addressgen dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .req_start_i  (req_start_i),
    .ctrl_i       (ctrl_i),
    .ready_start_o(ready_start_o),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_last_o  (addr_last_o),
    .addr_ready_i (addr_ready_i),
    .done_o       (done_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Address n = base + f*feat_stride + l*line_stride + w*4 with w, l, f
  // obtained by dividing n by the (zero-treated-as-one) line/feature sizes.
  function automatic void model_fill(input ctrl_addressgen_t d);
    longint len_l = (d.line_length == 0) ? 1 : longint'(d.line_length);
    longint len_f = (d.feat_length == 0) ? 1 : longint'(d.feat_length);
    for (int n = 0; n < int'(d.trans_size); n++) begin
      longint w = n % len_l;
      longint l = (n / len_l) % len_f;
      longint f = n / (len_l * len_f);
      longint s = longint'(d.base_addr) + f * longint'(d.feat_stride)
                + l * longint'(d.line_stride) + w * 4;
      exp_q.push_back(32'(s));
    end
  endfunction

  function automatic ctrl_addressgen_t mk(input logic [31:0] base, input int ts,
                                          input int ll, input logic [31:0] ls,
                                          input int fl, input logic [31:0] fs);
    ctrl_addressgen_t d;
    d.base_addr   = base;
    d.trans_size  = 16'(ts);
    d.line_length = 16'(ll);
    d.line_stride = ls;
    d.feat_length = 16'(fl);
    d.feat_stride = fs;
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst_i) begin
      if (stall_prev && !clr_prev) chk("valid_held", addr_valid_o, 1'b1);
      if (addr_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", addr_valid_o, 1'b0);
        end else begin
          chk("addr", addr_o, exp_q[0]);
          chk("last", addr_last_o, exp_q.size() == 1);
          if (addr_ready_i) void'(exp_q.pop_front());
        end
      end
    end
    stall_prev = addr_valid_o && !addr_ready_i;
    clr_prev   = clear_i || rst_i;
  end

  // Entered and left at one time unit after a rising edge.
  task automatic run_xfer(input ctrl_addressgen_t d, input int mode, input bit poke,
                          output int done_cyc, output int hs);
    chk("idle_ready_start", ready_start_o, 1'b1);
    req_start_i  = 1'b1;
    ctrl_i       = d;
    addr_ready_i = 1'b0;
    @(posedge clk); #1;
    req_start_i        = 1'b0;
    ctrl_i.base_addr   = $urandom;
    ctrl_i.trans_size  = 16'($urandom);
    ctrl_i.line_length = 16'($urandom);
    ctrl_i.line_stride = $urandom;
    ctrl_i.feat_length = 16'($urandom);
    ctrl_i.feat_stride = $urandom;
    done_cyc = -1;
    hs       = 0;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      addr_ready_i = (mode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
      if (poke) req_start_i = (cyc == 2);
      @(negedge clk);
      chk("busy_ready_start", ready_start_o, 1'b0);
      if (addr_valid_o && addr_ready_i) hs++;
      if (done_o) begin
        done_cyc = cyc;
        chk("done_queue_empty", 64'(exp_q.size()), 0);
        chk("done_no_valid", addr_valid_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    req_start_i = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout actual=no_done expected=done_within_300");
    end
    chk("post_done_ready_start", ready_start_o, 1'b1);
    chk("done_single_pulse", done_o, 1'b0);
  endtask

  task automatic quiet_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_valid"}, addr_valid_o, 1'b0);
      chk({name, "_done"}, done_o, 1'b0);
      chk({name, "_ready_start"}, ready_start_o, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ctrl_addressgen_t d;
    int dc;
    int hs;

    rst_i        = 1'b1;
    clear_i      = 1'b0;
    req_start_i  = 1'b0;
    addr_ready_i = 1'b0;
    ctrl_i       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_start", ready_start_o, 1'b1);
    chk("rst_valid", addr_valid_o, 1'b0);
    chk("rst_last", addr_last_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_addr", addr_o, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Contiguous line, no stall.
    d = mk(32'h1000, 4, 4, 32'h0, 1, 32'h0);
    model_fill(d);
    chk("model_s1_last", exp_q[3], 32'h100C);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("s1_done_cycle", 64'(dc), 5);
    chk("s1_handshakes", 64'(hs), 4);

    // Strided 2-D pattern.
    d = mk(32'h0, 6, 2, 32'h100, 2, 32'h1000);
    model_fill(d);
    chk("model_2d_n2", exp_q[2], 32'h100);
    chk("model_2d_n5", exp_q[5], 32'h1004);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("s2_done_cycle", 64'(dc), 7);

    // Backpressure with ready 1,0,0,1,0,0,...
    d = mk(32'h1000, 4, 4, 32'h0, 1, 32'h0);
    model_fill(d);
    run_xfer(d, 1, 1'b0, dc, hs);
    chk("s3_done_cycle", 64'(dc), 11);
    chk("s3_handshakes", 64'(hs), 4);

    // Zero-length transfer.
    d = mk(32'h1234, 0, 4, 32'h0, 1, 32'h0);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("zero_done_cycle", 64'(dc), 1);
    chk("zero_handshakes", 64'(hs), 0);

    // Address wrap-around.
    d = mk(32'hFFFF_FFFC, 2, 4, 32'h0, 1, 32'h0);
    model_fill(d);
    chk("model_wrap_n1", exp_q[1], 32'h0);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("wrap_done_cycle", 64'(dc), 3);

    // Zero line/feature length behave as one.
    d = mk(32'h40, 3, 0, 32'h10, 0, 32'h100);
    model_fill(d);
    chk("model_zero_len_n2", exp_q[2], 32'h240);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("zero_len_done_cycle", 64'(dc), 4);

    // Start request pulsed while running is ignored.
    d = mk(32'h2000, 5, 8, 32'h0, 1, 32'h0);
    model_fill(d);
    run_xfer(d, 0, 1'b1, dc, hs);
    chk("ignored_start_done_cycle", 64'(dc), 6);
    chk("ignored_start_handshakes", 64'(hs), 5);

    // Clear after two of eight addresses.
    d = mk(32'h3000, 8, 8, 32'h0, 1, 32'h0);
    model_fill(d);
    chk("clr_idle_ready_start", ready_start_o, 1'b1);
    req_start_i = 1'b1;
    ctrl_i      = d;
    @(posedge clk); #1;
    req_start_i  = 1'b0;
    addr_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    clear_i      = 1'b1;
    addr_ready_i = 1'b0;
    @(negedge clk);
    chk("pre_clear_valid", addr_valid_o, 1'b1);
    chk("pre_clear_addr", addr_o, 32'h3008);
    @(posedge clk); #1;
    clear_i = 1'b0;
    exp_q.delete();
    quiet_cycles("after_clear", 3);

    // Restart after clear from its own base.
    d = mk(32'h5000, 3, 3, 32'h0, 1, 32'h0);
    model_fill(d);
    run_xfer(d, 0, 1'b0, dc, hs);
    chk("restart_done_cycle", 64'(dc), 4);

    // Clear together with start: start is dropped.
    clear_i     = 1'b1;
    req_start_i = 1'b1;
    ctrl_i      = mk(32'h6000, 3, 3, 32'h0, 1, 32'h0);
    @(posedge clk); #1;
    clear_i     = 1'b0;
    req_start_i = 1'b0;
    quiet_cycles("clear_vs_start", 2);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
